// File: rtl/ysyx_23060025_clint_pkg.sv
// Shared constants for the CLINT slave: register offsets, AXI responses, FSM encodings.
package ysyx_23060025_clint_pkg;

    localparam logic [15:0] CLINT_MTIME_LO_OFF = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF = 16'hBFFC;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [0:0] CLINT_IDLE = 1'b0;
    localparam logic [0:0] CLINT_RESP = 1'b1;

    // Crossbar port selector that routes requests to this block.
    localparam logic [1:0] AXI_XBAR_CLINT = 2'd2;

endpackage

// File: rtl/ysyx_23060025_clint_timer.sv
// Free-running 64-bit mtime counter.
// With CLINT_PRESCALE_EN defined, mtime advances once every PRESCALE cycles.
module ysyx_23060025_clint_timer #(
    parameter int PRESCALE = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic [63:0] mtime_o
);

    logic [63:0] mtime_q;
    logic        tick;

`ifdef CLINT_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Wraps silently from all-ones back to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            mtime_q <= '0;
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/ysyx_23060025_clint.sv
// CLINT read slave behind the crossbar: serves mtime over AR/R with a hi snapshot.
// Build option: CLINT_PRESCALE_EN enables the mtime prescaler in the timer.
module ysyx_23060025_clint
    import ysyx_23060025_clint_pkg::*;
#(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DATA_LEN   = 32,
    parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000,
    parameter int                  PRESCALE   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] clint_addr_r_addr_i,
    input  logic                clint_addr_r_valid_i,
    output logic                clint_addr_r_ready_o,
    output logic [DATA_LEN-1:0] clint_r_data_o,
    output logic [1:0]          clint_r_resp_o,
    output logic                clint_r_valid_o,
    input  logic                clint_r_ready_i
);

    logic [63:0]         mtime;
    logic [31:0]         hi_shadow;
    logic [0:0]          state;
    logic [ADDR_LEN-1:0] offset;
    logic                in_window;
    logic                hit_lo;
    logic                hit_hi;

    ysyx_23060025_clint_timer #(
        .PRESCALE(PRESCALE)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .mtime_o(mtime)
    );

    assign offset    = clint_addr_r_addr_i - CLINT_BASE;
    assign in_window = (offset[ADDR_LEN-1:16] == '0);
    assign hit_lo    = in_window && (offset[15:0] == CLINT_MTIME_LO_OFF);
    assign hit_hi    = in_window && (offset[15:0] == CLINT_MTIME_HI_OFF);

    assign clint_addr_r_ready_o = (state == CLINT_IDLE) && !reset;
    assign clint_r_valid_o      = (state == CLINT_RESP);

    // A LO read snapshots the upper half so the following HI read is coherent.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= CLINT_IDLE;
            hi_shadow      <= '0;
            clint_r_data_o <= '0;
            clint_r_resp_o <= AXI_RESP_OKAY;
        end else begin
            case (state)
                CLINT_IDLE: begin
                    if (clint_addr_r_valid_i && clint_addr_r_ready_o) begin
                        state <= CLINT_RESP;
                        if (hit_lo) begin
                            clint_r_data_o <= mtime[31:0];
                            clint_r_resp_o <= AXI_RESP_OKAY;
                            hi_shadow      <= mtime[63:32];
                        end else if (hit_hi) begin
                            clint_r_data_o <= hi_shadow;
                            clint_r_resp_o <= AXI_RESP_OKAY;
                        end else begin
                            clint_r_data_o <= '0;
                            clint_r_resp_o <= AXI_RESP_SLVERR;
                        end
                    end
                end
                CLINT_RESP: begin
                    if (clint_r_ready_i) begin
                        state <= CLINT_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_clint.sv
// Directed self-checking bench for ysyx_23060025_clint (mtime reads, shadow, errors, backpressure).
module tb_ysyx_23060025_clint;
    import ysyx_23060025_clint_pkg::*;

    localparam logic [31:0] ADDR_LO  = 32'h0200_BFF8;
    localparam logic [31:0] ADDR_HI  = 32'h0200_BFFC;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic [1:0]  rr;
    int          lat;

    ysyx_23060025_clint #(
        .ADDR_LEN  (32),
        .DATA_LEN  (32),
        .CLINT_BASE(32'h0200_0000),
        .PRESCALE  (8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .clint_addr_r_addr_i (ar_addr),
        .clint_addr_r_valid_i(ar_valid),
        .clint_addr_r_ready_o(ar_ready),
        .clint_r_data_o      (r_data),
        .clint_r_resp_o      (r_resp),
        .clint_r_valid_o     (r_valid),
        .clint_r_ready_i     (r_ready)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one read starting #1 after an edge; returns the beat and AR-to-R latency.
    task automatic applyStimulus(input logic [31:0] addr, output logic [31:0] data,
                                 output logic [1:0] resp, output int latency);
        ar_addr  = addr;
        ar_valid = 1'b1;
        latency  = 0;
        do begin
            @(posedge clock);
            #1;
            latency++;
        end while (!r_valid && latency < 20);
        ar_valid = 1'b0;
        checkOutput("r_valid_seen", 64'(r_valid), 64'd1);
        data = r_data;
        resp = r_resp;
        if (r_ready) begin
            @(posedge clock);
            #1;
            checkOutput("r_valid_drop", 64'(r_valid), 64'd0);
        end
    endtask

    task automatic releaseReset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_ready", 64'(ar_ready), 64'd0);
        checkOutput("rst_valid", 64'(r_valid), 64'd0);
        checkOutput("rst_data", 64'(r_data), 64'd0);
        checkOutput("rst_resp", 64'(r_resp), 64'd0);
        reset = 1'b0;

`ifdef CLINT_PRESCALE_EN
        repeat (7) @(posedge clock);
        #1;
        applyStimulus(ADDR_LO, rd, rr, lat);
        checkOutput("pre7_data", 64'(rd), 64'd0);
        checkOutput("pre7_resp", 64'(rr), 64'd0);

        releaseReset();
        repeat (8) @(posedge clock);
        #1;
        applyStimulus(ADDR_LO, rd, rr, lat);
        checkOutput("pre8_data", 64'(rd), 64'd1);
        checkOutput("pre8_resp", 64'(rr), 64'd0);

        applyStimulus(ADDR_HI, rd, rr, lat);
        checkOutput("pre_hi", 64'(rd), 64'd0);
`else
        // First LO read: handshake on the 11th edge after release samples 10.
        repeat (10) @(posedge clock);
        #1;
        applyStimulus(ADDR_LO, rd, rr, lat);
        checkOutput("lo10_data", 64'(rd), 64'd10);
        checkOutput("lo10_resp", 64'(rr), 64'd0);
        checkOutput("lo10_latency", 64'(lat), 64'd1);

        // Carry out of bit 31 between the LO and HI reads.
        dut.u_timer.mtime_q = 64'h0000_0000_FFFF_FFFF;
        applyStimulus(ADDR_LO, rd, rr, lat);
        checkOutput("carry_lo", 64'(rd), 64'h0000_0000_FFFF_FFFF);
        checkOutput("carry_live_hi", 64'(dut.u_timer.mtime_q[63:32]), 64'd1);
        applyStimulus(ADDR_HI, rd, rr, lat);
        checkOutput("carry_hi_shadow", 64'(rd), 64'd0);
        checkOutput("carry_hi_resp", 64'(rr), 64'd0);

        // Error reads must leave the shadow alone.
        dut.u_timer.mtime_q = 64'h0000_0005_0000_0100;
        applyStimulus(ADDR_LO, rd, rr, lat);
        checkOutput("shadow_lo", 64'(rd), 64'h100);
        applyStimulus(32'h0200_0000, rd, rr, lat);
        checkOutput("err_base_resp", 64'(rr), 64'(AXI_RESP_SLVERR));
        checkOutput("err_base_data", 64'(rd), 64'd0);
        applyStimulus(32'h0201_BFF8, rd, rr, lat);
        checkOutput("err_upper_resp", 64'(rr), 64'(AXI_RESP_SLVERR));
        applyStimulus(32'h0100_BFF8, rd, rr, lat);
        checkOutput("err_below_resp", 64'(rr), 64'(AXI_RESP_SLVERR));
        applyStimulus(ADDR_HI, rd, rr, lat);
        checkOutput("shadow_hi", 64'(rd), 64'd5);
        checkOutput("shadow_hi_resp", 64'(rr), 64'd0);

        // Backpressure: R held for 5 cycles while a HI request waits on AR.
        r_ready  = 1'b0;
        dut.u_timer.mtime_q = 64'h0000_0007_1234_5678;
        ar_addr  = ADDR_LO;
        ar_valid = 1'b1;
        @(posedge clock);
        #1;
        ar_addr = ADDR_HI;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 64'(r_valid), 64'd1);
            checkOutput("bp_data", 64'(r_data), 64'h1234_5678);
            checkOutput("bp_resp", 64'(r_resp), 64'd0);
            checkOutput("bp_ready", 64'(ar_ready), 64'd0);
            @(posedge clock);
            #1;
        end
        r_ready = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("bp_r_done", 64'(r_valid), 64'd0);
        checkOutput("bp_ar_ready", 64'(ar_ready), 64'd1);
        @(posedge clock);
        #1;
        ar_valid = 1'b0;
        checkOutput("bp_second_valid", 64'(r_valid), 64'd1);
        checkOutput("bp_second_data", 64'(r_data), 64'd7);
        @(posedge clock);
        #1;
        checkOutput("bp_second_done", 64'(r_valid), 64'd0);

        // 64-bit wrap of mtime.
        dut.u_timer.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clock);
        #1;
        checkOutput("wrap_mtime", dut.u_timer.mtime_q, 64'd0);

        // Reset while a beat is pending discards it.
        r_ready  = 1'b0;
        ar_addr  = ADDR_LO;
        ar_valid = 1'b1;
        @(posedge clock);
        #1;
        ar_valid = 1'b0;
        checkOutput("rr_pending", 64'(r_valid), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rr_valid", 64'(r_valid), 64'd0);
        checkOutput("rr_ready", 64'(ar_ready), 64'd0);
        checkOutput("rr_mtime", dut.u_timer.mtime_q, 64'd0);
        reset   = 1'b0;
        r_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        applyStimulus(ADDR_LO, rd, rr, lat);
        checkOutput("rr_after_data", 64'(rd), 64'd3);
        checkOutput("rr_after_resp", 64'(rr), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
